conv_compute_sequencer: RTL and testbench
=========================================

Name: conv_compute_sequencer

Overview:
- Controller stage directly upstream of the done-delay stage.
- On `start`, walks the MAC schedule for one layer: all input channels for every group of `PE_LANES` output channels.
- Drives the PE-array enables and accumulator control, then raises a level `done_compute` that the downstream delay stage consumes.
- `done_compute` stays high until the host acknowledges it.

Parameters:
- PE_LANES, 4, output channels computed in parallel per beat; power of two, at least 1.
- PIPE_LAT, 3, PE pipeline depth in cycles, drained after the last beat before done; at least 0.
- CNT_W, 32, width of the internal beat counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a layer; sampled only in IDLE
- IFM_C  in  16  input channel count; latched on accepted start
- OFM_C  in  16  output channel count; latched on accepted start
- stall  in  1  operand data not ready; freezes the RUN schedule
- done_clr  in  1  host acknowledge; clears done_compute
- pe_en  out  1  PE array computes this cycle
- ic_idx  out  16  current input channel index
- oc_idx  out  16  base output channel of the current lane group
- acc_clr  out  1  first beat of a lane group (ic_idx==0)
- acc_last  out  1  last beat of a lane group (ic_idx==IFM_C-1)
- busy  out  1  state is RUN or DRAIN
- done_compute  out  1  layer complete; level signal
- cfg_err  out  1  one-cycle pulse when start is rejected
- beat_cnt  out  CNT_W  beats issued since the last accepted start

Behaviour:
- Reset: on a clk edge with rst_n=0, every output and internal register goes to 0 and the state to IDLE. This holds mid-operation; no partial done is produced.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE, start=1 with IFM_C!=0 and OFM_C!=0:
  - latch IFM_C and OFM_C;
  - clear ic_idx, oc_idx and beat_cnt;
  - go to RUN.
- IDLE, start=1 with IFM_C==0 or OFM_C==0: cfg_err=1 for exactly one cycle; stay in IDLE.
- IDLE, start=0: nothing happens.
- RUN, stall=0:
  - pe_en=1 and beat_cnt+=1;
  - acc_clr = (ic_idx==0); acc_last = (ic_idx==IFM_C_latched-1);
  - if ic_idx==IFM_C-1, then ic_idx wraps to 0 and oc_idx += PE_LANES; otherwise ic_idx+=1.
- RUN, stall=1: pe_en, acc_clr and acc_last are 0; all indices and counters hold.
- Last beat: the beat with acc_last=1 and oc_idx+PE_LANES >= OFM_C_latched.
  - The next state is DRAIN, or DONE directly if PIPE_LAT==0.
  - The total beat count is IFM_C * ceil(OFM_C/PE_LANES).
- Partial final group: when OFM_C is not a multiple of PE_LANES, the final group still issues IFM_C beats. Lane masking belongs to the PE array.
- DRAIN: counts PIPE_LAT cycles regardless of stall; pe_en=0; then goes to DONE.
- DONE: done_compute=1 and busy=0. The state holds until done_clr=1, then returns to IDLE and done_compute drops on that edge.
- start is ignored in RUN, DRAIN and DONE.
- done_clr is ignored outside DONE.
- If done_clr and start are both high in DONE, go to IDLE only; the start is lost.
- Arithmetic:
  - index registers are 16-bit;
  - the oc_idx addition is done at 17 bits, so OFM_C=65535 terminates correctly with no wrap;
  - beat_cnt saturates at all-ones.
- Config latching: IFM_C and OFM_C changes after start do not affect the running layer.

Test Plan:
1. IFM_C=8, OFM_C=8, PE_LANES=4, no stall -> 16 pe_en beats on consecutive cycles.
   - acc_clr at beats 1 and 9; acc_last at beats 8 and 16; oc_idx goes 0 then 4.
   - done_compute rises 3 cycles after the last pe_en; beat_cnt=16.
2. IFM_C=3, OFM_C=5 -> 6 beats; oc_idx goes 0 then 4; done_compute after drain; held high for 20 cycles until done_clr pulses, then 0 the next cycle.
3. IFM_C=4, OFM_C=4, stall high on beats 2 and 3 for 5 cycles each -> exactly 4 pe_en pulses; ic_idx frozen during stall; done is 10 cycles later than the unstalled run.
4. start with IFM_C=0, OFM_C=16 -> cfg_err high for one cycle; state stays IDLE; pe_en never asserts. Then start with IFM_C=1, OFM_C=1 -> 1 beat with acc_clr and acc_last both 1.
5. rst_n=0 for 1 cycle during beat 5 of the 8x8 run -> all outputs 0 on the next edge, done_compute never rises. A fresh start then runs a full 16 beats.
6. start pulsed during RUN and during DONE, and done_clr pulsed during RUN -> all ignored; the schedule and done timing are identical to scenario 1.

Source files
------------

// File: rtl/conv_compute_sequencer.sv
// Layer MAC schedule controller: walks input channels for each output lane group,
// drains the PE pipeline, then holds done_compute until the host acknowledges it.
module conv_compute_sequencer #(
  parameter int unsigned PE_LANES = 4,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      IFM_C,
  input  logic [15:0]      OFM_C,
  input  logic             stall,
  input  logic             done_clr,
  output logic             pe_en,
  output logic [15:0]      ic_idx,
  output logic [15:0]      oc_idx,
  output logic             acc_clr,
  output logic             acc_last,
  output logic             busy,
  output logic             done_compute,
  output logic             cfg_err,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  state_e             state_q, state_d;
  logic [15:0]        ifm_q, ifm_d, ofm_q, ofm_d;
  logic [15:0]        ic_cnt_q, ic_cnt_d, oc_cnt_q, oc_cnt_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               pe_en_q, pe_en_d, acc_clr_q, acc_clr_d, acc_last_q, acc_last_d;
  logic               busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [15:0]        ic_idx_q, ic_idx_d, oc_idx_q, oc_idx_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               last_ic, last_grp;
  logic [16:0]        oc_sum;

  // 17-bit sum so the final group of a 65535-channel layer is still recognised.
  assign oc_sum   = {1'b0, oc_cnt_q} + 17'(PE_LANES);
  assign last_ic  = (ic_cnt_q == ifm_q - 16'd1);
  assign last_grp = (oc_sum >= {1'b0, ofm_q});

  always_comb begin
    state_d    = state_q;
    ifm_d      = ifm_q;
    ofm_d      = ofm_q;
    ic_cnt_d   = ic_cnt_q;
    oc_cnt_d   = oc_cnt_q;
    drain_d    = drain_q;
    ic_idx_d   = ic_idx_q;
    oc_idx_d   = oc_idx_q;
    beat_cnt_d = beat_cnt_q;
    pe_en_d    = 1'b0;
    acc_clr_d  = 1'b0;
    acc_last_d = 1'b0;
    cfg_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (IFM_C != 16'd0 && OFM_C != 16'd0) begin
            ifm_d      = IFM_C;
            ofm_d      = OFM_C;
            ic_cnt_d   = 16'd0;
            oc_cnt_d   = 16'd0;
            ic_idx_d   = 16'd0;
            oc_idx_d   = 16'd0;
            beat_cnt_d = '0;
            drain_d    = '0;
            state_d    = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!stall) begin
          // Outputs describe the beat being issued; the *_cnt registers point at the next one.
          pe_en_d    = 1'b1;
          ic_idx_d   = ic_cnt_q;
          oc_idx_d   = oc_cnt_q;
          acc_clr_d  = (ic_cnt_q == 16'd0);
          acc_last_d = last_ic;
          if (beat_cnt_q != {CNT_W{1'b1}}) beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_ic) begin
            ic_cnt_d = 16'd0;
            oc_cnt_d = oc_cnt_q + 16'(PE_LANES);
            if (last_grp) begin
              drain_d = '0;
              state_d = (PIPE_LAT == 0) ? StDone : StDrain;
            end
          end else begin
            ic_cnt_d = ic_cnt_q + 16'd1;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StDone;
        else                      drain_d = drain_q + DrainW'(1);
      end
      StDone: begin
        if (done_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ifm_q      <= '0;
      ofm_q      <= '0;
      ic_cnt_q   <= '0;
      oc_cnt_q   <= '0;
      drain_q    <= '0;
      ic_idx_q   <= '0;
      oc_idx_q   <= '0;
      beat_cnt_q <= '0;
      pe_en_q    <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ifm_q      <= ifm_d;
      ofm_q      <= ofm_d;
      ic_cnt_q   <= ic_cnt_d;
      oc_cnt_q   <= oc_cnt_d;
      drain_q    <= drain_d;
      ic_idx_q   <= ic_idx_d;
      oc_idx_q   <= oc_idx_d;
      beat_cnt_q <= beat_cnt_d;
      pe_en_q    <= pe_en_d;
      acc_clr_q  <= acc_clr_d;
      acc_last_q <= acc_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign pe_en        = pe_en_q;
  assign ic_idx       = ic_idx_q;
  assign oc_idx       = oc_idx_q;
  assign acc_clr      = acc_clr_q;
  assign acc_last     = acc_last_q;
  assign busy         = busy_q;
  assign done_compute = done_q;
  assign cfg_err      = cfg_err_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_conv_compute_sequencer.sv
// Directed bench for conv_compute_sequencer: table of layer shapes plus
// hand-written reset, config-error and acknowledge sequences.
module tb_conv_compute_sequencer;

  localparam int Lanes = 4;
  localparam int Lat   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        done_clr = 1'b0;
  logic [15:0] IFM_C = 16'd0;
  logic [15:0] OFM_C = 16'd0;
  logic        pe_en, acc_clr, acc_last, busy, done_compute, cfg_err;
  logic [15:0] ic_idx, oc_idx;
  logic [31:0] beat_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  conv_compute_sequencer #(
    .PE_LANES(Lanes),
    .PIPE_LAT(Lat),
    .CNT_W   (32)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .IFM_C       (IFM_C),
    .OFM_C       (OFM_C),
    .stall       (stall),
    .done_clr    (done_clr),
    .pe_en       (pe_en),
    .ic_idx      (ic_idx),
    .oc_idx      (oc_idx),
    .acc_clr     (acc_clr),
    .acc_last    (acc_last),
    .busy        (busy),
    .done_compute(done_compute),
    .cfg_err     (cfg_err),
    .beat_cnt    (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ifm;
    int ofm;
    int beats;    // hand-computed IFM_C * ceil(OFM_C/4)
    int sa;       // beat preceded by a stall (0 = none)
    int sb;
    int slen;
    bit noise;    // stray start/done_clr pulses while running and in DONE
    int hold;     // extra cycles done is held before the acknowledge
    bit cws;      // start raised together with done_clr
    int done_at;  // cycles after the start edge at which done_compute is seen
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pe_en"}, 32'(pe_en), 0);
    chk({tag, "_ic_idx"}, 32'(ic_idx), 0);
    chk({tag, "_oc_idx"}, 32'(oc_idx), 0);
    chk({tag, "_acc_clr"}, 32'(acc_clr), 0);
    chk({tag, "_acc_last"}, 32'(acc_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done_compute), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    bit got;
    IFM_C = 16'(v.ifm);
    OFM_C = 16'(v.ofm);
    start = 1'b1;
    step();
    start = 1'b0;
    IFM_C = 16'hFFFF;  // must not disturb the latched layer shape
    OFM_C = 16'h0001;
    chk("run_entry_busy", 32'(busy), 1);
    chk("run_entry_pe_en", 32'(pe_en), 0);
    cyc = 1;
    for (int b = 1; b <= v.beats; b++) begin
      if (b == v.sa || b == v.sb) begin
        stall = 1'b1;
        for (int s = 0; s < v.slen; s++) begin
          step();
          cyc++;
          chk("stall_pe_en", 32'(pe_en), 0);
          chk("stall_beat_cnt", beat_cnt, b - 1);
          if (b > 1) chk("stall_ic_idx", 32'(ic_idx), (b - 2) % v.ifm);
        end
        stall = 1'b0;
      end
      if (v.noise && b == 2) start = 1'b1;
      if (v.noise && b == 3) done_clr = 1'b1;
      step();
      cyc++;
      start = 1'b0;
      done_clr = 1'b0;
      chk("beat_pe_en", 32'(pe_en), 1);
      chk("beat_ic_idx", 32'(ic_idx), (b - 1) % v.ifm);
      chk("beat_oc_idx", 32'(oc_idx), ((b - 1) / v.ifm) * Lanes);
      chk("beat_acc_clr", 32'(acc_clr), 32'((b - 1) % v.ifm == 0));
      chk("beat_acc_last", 32'(acc_last), 32'((b - 1) % v.ifm == v.ifm - 1));
      chk("beat_cnt", beat_cnt, b);
      chk("beat_busy", 32'(busy), 1);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      cyc++;
      if (done_compute) got = 1'b1;
      else begin
        chk("drain_pe_en", 32'(pe_en), 0);
        chk("drain_busy", 32'(busy), 1);
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: done_compute never rose, required at cycle %0d", v.done_at);
      return;
    end
    chk("done_cycle", cyc, v.done_at);
    chk("done_busy", 32'(busy), 0);
    chk("done_pe_en", 32'(pe_en), 0);
    chk("done_beat_cnt", beat_cnt, v.beats);
    if (v.noise) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk("done_start_ignored", 32'(done_compute), 1);
      chk("done_start_busy", 32'(busy), 0);
    end
    repeat (v.hold) step();
    chk("done_held", 32'(done_compute), 1);
    done_clr = 1'b1;
    if (v.cws) begin
      start = 1'b1;
      IFM_C = 16'd2;
      OFM_C = 16'd2;
    end
    step();
    done_clr = 1'b0;
    start = 1'b0;
    chk("ack_done", 32'(done_compute), 0);
    chk("ack_busy", 32'(busy), 0);
    step();
    chk("post_ack_pe_en", 32'(pe_en), 0);
    chk("post_ack_busy", 32'(busy), 0);
  endtask

  vec_t tab[6];

  initial begin
    tab[0] = '{ifm: 8, ofm: 8, beats: 16, sa: 0, sb: 0, slen: 0, noise: 0, hold: 0, cws: 0,
               done_at: 20};
    tab[1] = '{ifm: 3, ofm: 5, beats: 6, sa: 0, sb: 0, slen: 0, noise: 0, hold: 20, cws: 0,
               done_at: 10};
    tab[2] = '{ifm: 4, ofm: 4, beats: 4, sa: 0, sb: 0, slen: 0, noise: 0, hold: 0, cws: 0,
               done_at: 8};
    tab[3] = '{ifm: 4, ofm: 4, beats: 4, sa: 2, sb: 3, slen: 5, noise: 0, hold: 0, cws: 0,
               done_at: 18};
    tab[4] = '{ifm: 8, ofm: 8, beats: 16, sa: 0, sb: 0, slen: 0, noise: 1, hold: 0, cws: 0,
               done_at: 20};
    tab[5] = '{ifm: 2, ofm: 9, beats: 6, sa: 0, sb: 0, slen: 0, noise: 0, hold: 3, cws: 1,
               done_at: 10};

    rst_n = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_zero("idle");

    foreach (tab[i]) run_vec(tab[i]);

    // Rejected starts: either channel count zero.
    IFM_C = 16'd0;
    OFM_C = 16'd16;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_busy", 32'(busy), 0);
    step();
    chk("cfg_err_drop", 32'(cfg_err), 0);
    IFM_C = 16'd5;
    OFM_C = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_ofm0", 32'(cfg_err), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cfg_err_no_pe", 32'(pe_en), 0);
      chk("cfg_err_idle", 32'(busy), 0);
    end

    // Single-beat layer: acc_clr and acc_last on the same beat.
    run_vec('{ifm: 1, ofm: 1, beats: 1, sa: 0, sb: 0, slen: 0, noise: 0, hold: 0, cws: 0,
              done_at: 5});

    // Reset in the middle of the 8x8 layer.
    IFM_C = 16'd8;
    OFM_C = 16'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("midrun_pe_en", 32'(pe_en), 1);
    chk("midrun_beat_cnt", beat_cnt, 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero("midrun_reset");
    for (int i = 0; i < 25; i++) begin
      step();
      chk("after_reset_done", 32'(done_compute), 0);
      chk("after_reset_pe_en", 32'(pe_en), 0);
    end
    run_vec(tab[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
